// File: rtl/lcd_pkg.sv
// Shared types and helpers for the SM510 LCD capture path.
//   NUM_COM / SEG_PER_COM : scan geometry (4 commons x 32 segments)
//   seg_row_t / seg_frame_t: one common's segment row / a full bitmap
//   lcd_state_t            : phase-detect FSM states
//   split_rd_addr()        : splits the read address into common and segment
package lcd_pkg;

    localparam int NUM_COM     = 4;
    localparam int SEG_PER_COM = 32;

    typedef logic [SEG_PER_COM-1:0] seg_row_t;
    typedef seg_row_t [NUM_COM-1:0] seg_frame_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } lcd_state_t;

    typedef struct packed {
        logic [1:0] com;
        logic [4:0] seg;
    } rd_sel_t;

    // rd_addr[6:5] selects the common, rd_addr[4:0] the segment within it.
    function automatic rd_sel_t split_rd_addr(input logic [6:0] addr);
        rd_sel_t sel;
        sel.com = addr[6:5];
        sel.seg = addr[4:0];
        return sel;
    endfunction

endpackage

// File: rtl/lcd_phase_detect.sv
// Common-strobe phase detector.
// Tracks the previous H value, flags changes, checks for one-hot, encodes
// the active common index and waits SETTLE cycles before requesting a sample.
//   clk, rst  : clock, synchronous active-high reset
//   h         : common strobes
//   valid_chg : combinational, H changed this cycle to a one-hot value
//   sample    : high for the one cycle the segment buses must be captured
//   abort     : one-cycle pulse after a change to a non-one-hot H
//   phase     : index of the common being settled / sampled
//   state     : FSM state, exported for observation
module lcd_phase_detect
    import lcd_pkg::*;
#(
    parameter int SETTLE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] h,
    output logic       valid_chg,
    output logic       sample,
    output logic       abort,
    output logic [1:0] phase,
    output lcd_state_t state
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);

    logic [3:0] h_prev;
    logic [7:0] settle_cnt;
    logic       change;
    logic       one_hot;
    logic [1:0] enc;

    assign change    = (h != h_prev);
    assign one_hot   = (h != 4'd0) && ((h & (h - 4'd1)) == 4'd0);
    assign valid_chg = change && one_hot;
    // Only meaningful when h is one-hot.
    assign enc       = {h[3] | h[2], h[3] | h[1]};
    // SAMPLE lasts exactly one cycle, so the strobe is the state decode.
    assign sample    = (state == ST_SAMPLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            h_prev     <= 4'd0;
            settle_cnt <= 8'd0;
            phase      <= 2'd0;
            abort      <= 1'b0;
            state      <= ST_IDLE;
        end else begin
            h_prev <= h;
            abort  <= 1'b0;
            // Any change restarts the sequence from whatever state we are in,
            // so a change during the last settle cycle suppresses the sample.
            if (change) begin
                if (one_hot) begin
                    settle_cnt <= SETTLE_LOAD;
                    phase      <= enc;
                    state      <= ST_SETTLE;
                end else begin
                    abort <= 1'b1;
                    state <= ST_IDLE;
                end
            end else begin
                case (state)
                    ST_SETTLE: begin
                        if (settle_cnt == 8'd0) begin
                            state <= ST_SAMPLE;
                        end else begin
                            settle_cnt <= settle_cnt - 8'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/lcd_frame_capture.sv
// SM510 LCD frame capture.
// Reassembles complete, in-order 4-common scans into a bitmap and commits it
// atomically to the display buffer; a watchdog blanks the buffer when the
// scan stops.
//   clk, rst   : clock, synchronous active-high reset
//   H          : common strobes (one-hot when valid)
//   segA, segB : segments 0-15 / 16-31 of the active common
//   Bs         : background segment level of the active common
//   rd_addr    : {common[1:0], segment[4:0]} read address
//   rd_data    : display bit at rd_addr, one cycle later
//   bs_vec     : committed Bs per common
//   frame_done : one-cycle pulse on each commit
//   frame_cnt  : number of commits, wrapping
//   blanked    : display buffer forced blank by the watchdog
module lcd_frame_capture
    import lcd_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  H,
    input  logic [15:0] segA,
    input  logic [15:0] segB,
    input  logic        Bs,
    input  logic [6:0]  rd_addr,
    output logic        rd_data,
    output logic [3:0]  bs_vec,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        blanked
);

    localparam int            TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic       valid_chg;
    logic       sample;
    logic       abort;
    logic [1:0] phase;
    // FSM state tap kept for bound checkers; the datapath does not read it.
    lcd_state_t phase_state_unused;

    seg_frame_t      shadow;
    seg_frame_t      display;
    logic [3:0]      shadow_bs;
    logic [3:0]      seen;
    logic [3:0]      seen_next;
    logic            commit_pend;
    logic [TO_W-1:0] to_cnt;
    logic            expire;
    rd_sel_t         rd_sel;

    lcd_phase_detect #(
        .SETTLE(SETTLE)
    ) u_phase (
        .clk      (clk),
        .rst      (rst),
        .h        (H),
        .valid_chg(valid_chg),
        .sample   (sample),
        .abort    (abort),
        .phase    (phase),
        .state    (phase_state_unused)
    );

    assign rd_sel = split_rd_addr(rd_addr);

    // Commons must arrive strictly as 0,1,2,3: common 0 always restarts the
    // mask, a later common only extends it if its predecessor is the highest
    // bit seen so far; anything else throws the partial frame away.
    always_comb begin
        seen_next = 4'd0;
        if (phase == 2'd0) begin
            seen_next = 4'b0001;
        end else if (seen[phase - 2'd1] && ((seen >> phase) == 4'd0)) begin
            seen_next = seen | (4'b0001 << phase);
        end
    end

    // A commit in the same cycle resets the counter, so it overrides expiry.
    assign expire = !valid_chg && !commit_pend && (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow      <= '0;
            shadow_bs   <= 4'd0;
            display     <= '0;
            seen        <= 4'd0;
            commit_pend <= 1'b0;
            to_cnt      <= '0;
            rd_data     <= 1'b0;
            bs_vec      <= 4'd0;
            frame_done  <= 1'b0;
            frame_cnt   <= 16'd0;
            blanked     <= 1'b1;
        end else begin
            frame_done  <= 1'b0;
            commit_pend <= 1'b0;

            if (sample) begin
                shadow[phase]    <= {segB, segA};
                shadow_bs[phase] <= Bs;
                seen             <= seen_next;
                commit_pend      <= (phase == 2'd3) && (seen_next == 4'b1111);
            end else if (abort) begin
                seen <= 4'd0;
            end

            // The shadow already holds row 3 here: it was written in the
            // sample cycle that raised commit_pend.
            if (commit_pend) begin
                display    <= shadow;
                bs_vec     <= shadow_bs;
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 16'd1;
                blanked    <= 1'b0;
                seen       <= 4'd0;
                to_cnt     <= '0;
            end else begin
                if (valid_chg) begin
                    to_cnt <= '0;
                end else if (to_cnt != TO_MAX) begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
                if (expire) begin
                    display <= '0;
                    bs_vec  <= 4'd0;
                    blanked <= 1'b1;
                    seen    <= 4'd0;
                end
            end

            // Reads the pre-update buffer, so a read in the commit cycle
            // still returns the old frame.
            rd_data <= display[rd_sel.com][rd_sel.seg];
        end
    end

endmodule

// File: tb/tb_lcd_frame_capture.sv
// Self-checking bench for lcd_frame_capture.
// dut runs SETTLE=4/TIMEOUT=100; dut_b shares the stimulus with TIMEOUT=6 so
// that a 6-cycle-per-common scan lands its commit on the watchdog expiry.
module tb_lcd_frame_capture;

    localparam int W = 20;  // {frame_cnt, bs_vec}

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  H = 4'd0;
    logic [15:0] segA = 16'd0;
    logic [15:0] segB = 16'd0;
    logic        Bs = 1'b0;
    logic [6:0]  rd_addr = 7'd0;

    logic        rd_data, frame_done, blanked;
    logic [3:0]  bs_vec;
    logic [15:0] frame_cnt;
    logic        rd_data_b, frame_done_b, blanked_b;
    logic [3:0]  bs_vec_b;
    logic [15:0] frame_cnt_b;

    logic [W-1:0] exp_q[$];
    logic [15:0]  mdl_cnt = 16'd0;
    logic [31:0]  mdl_row [4];

    int n_vec = 0;
    int n_err = 0;

    lcd_frame_capture #(.SETTLE(4), .TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .H(H), .segA(segA), .segB(segB), .Bs(Bs),
        .rd_addr(rd_addr), .rd_data(rd_data), .bs_vec(bs_vec),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .blanked(blanked)
    );

    lcd_frame_capture #(.SETTLE(4), .TIMEOUT(6)) dut_b (
        .clk(clk), .rst(rst), .H(H), .segA(segA), .segB(segB), .Bs(Bs),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .bs_vec(bs_vec_b),
        .frame_done(frame_done_b), .frame_cnt(frame_cnt_b), .blanked(blanked_b)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every frame_done of dut consumes one expected commit.
    always @(negedge clk) begin
        if (!rst && frame_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_frame_done", 32'(frame_done), 32'd0);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("sb_frame_cnt", 32'(frame_cnt), 32'(e[19:4]));
                check("sb_bs_vec", 32'(bs_vec), 32'(e[3:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_model();
        exp_q.delete();
        mdl_cnt = 16'd0;
        for (int r = 0; r < 4; r++) mdl_row[r] = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        H   = 4'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    // Called when a scan that must commit is about to be driven.
    task automatic expect_frame(input logic [3:0] bsm);
        mdl_cnt = mdl_cnt + 16'd1;
        exp_q.push_back({mdl_cnt, bsm});
        for (int r = 0; r < 4; r++) mdl_row[r] = {segB, segA};
    endtask

    // ord holds four 2-bit common indices, first common in the low bits.
    task automatic scan(input logic [7:0] ord, input int hold, input int last_hold,
                        input logic [3:0] bsm);
        for (int i = 0; i < 4; i++) begin
            int c;
            c  = int'(ord[2*i +: 2]);
            H  = 4'(4'b0001 << c);
            Bs = bsm[c];
            repeat ((i == 3) ? last_hold : hold) @(negedge clk);
        end
    endtask

    task automatic wait_frame(input string tag);
        for (int i = 0; i < 32 && frame_done !== 1'b1; i++) @(negedge clk);
        check(tag, 32'(frame_done), 32'd1);
    endtask

    task automatic wait_frame_b(input string tag);
        for (int i = 0; i < 32 && frame_done_b !== 1'b1; i++) @(negedge clk);
        check(tag, 32'(frame_done_b), 32'd1);
    endtask

    task automatic read_chk(input logic [6:0] addr, input string tag);
        logic e;
        rd_addr = addr;
        @(negedge clk);
        e = mdl_row[addr[6:5]][addr[4:0]];
        check(tag, 32'(rd_data), 32'(e));
    endtask

    task automatic read_chk_b(input logic [6:0] addr, input string tag);
        logic e;
        rd_addr = addr;
        @(negedge clk);
        e = mdl_row[addr[6:5]][addr[4:0]];
        check(tag, 32'(rd_data_b), 32'(e));
    endtask

    task automatic rand_reads(input int n, input string tag);
        for (int i = 0; i < n; i++) read_chk(7'($urandom_range(0, 127)), tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clear_model();
        do_reset();

        // Reset state
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_bs_vec", 32'(bs_vec), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_blanked", 32'(blanked), 32'd1);
        check("rst_rd_data", 32'(rd_data), 32'd0);

        // Basic in-order scan
        segA = 16'hA5A5; segB = 16'h0F0F;
        expect_frame(4'b0100);
        scan(8'hE4, 20, 20, 4'b0100);
        check("basic_drain", exp_q.size(), 32'd0);
        check("basic_frame_cnt", 32'(frame_cnt), 32'd1);
        check("basic_bs_vec", 32'(bs_vec), 32'h4);
        check("basic_blanked", 32'(blanked), 32'd0);
        read_chk(7'h00, "basic_rd_00");
        read_chk(7'h01, "basic_rd_01");
        read_chk(7'h30, "basic_rd_30");
        rand_reads(4, "basic_rd_rand");

        // Out-of-order commons, then a clean scan
        do_reset();
        segA = 16'h1234; segB = 16'h5678;
        scan(8'hD8, 20, 20, 4'b1111);
        check("ooo_no_commit", 32'(frame_cnt), 32'd0);
        segA = 16'hC3C3; segB = 16'h3C3C;
        expect_frame(4'b1010);
        scan(8'hE4, 20, 20, 4'b1010);
        check("ooo_clean_drain", exp_q.size(), 32'd0);
        check("ooo_clean_cnt", 32'(frame_cnt), 32'd1);
        read_chk(7'h22, "ooo_rd_22");
        rand_reads(3, "ooo_rd_rand");

        // Non-one-hot glitch while settling common 1
        segA = 16'hFFFF; segB = 16'hFFFF; Bs = 1'b1;
        H = 4'b0001; repeat (20) @(negedge clk);
        H = 4'b0011; repeat (2) @(negedge clk);
        H = 4'b0010; repeat (20) @(negedge clk);
        H = 4'b0100; repeat (20) @(negedge clk);
        H = 4'b1000; repeat (20) @(negedge clk);
        check("glitch_no_commit", 32'(frame_cnt), 32'd1);
        check("glitch_bs_kept", 32'(bs_vec), 32'hA);
        read_chk(7'h22, "glitch_row1_kept");
        segA = 16'h0001; segB = 16'h8000;
        expect_frame(4'b0001);
        scan(8'hE4, 20, 20, 4'b0001);
        check("glitch_clean_drain", exp_q.size(), 32'd0);
        check("glitch_clean_cnt", 32'(frame_cnt), 32'd2);
        read_chk(7'h00, "glitch_rd_00");
        read_chk(7'h3F, "glitch_rd_3f");
        read_chk(7'h41, "glitch_rd_41");

        // Watchdog: hold H after a frame and let it expire
        segA = 16'h00FF; segB = 16'hFF00;
        expect_frame(4'b0010);
        scan(8'hE4, 20, 0, 4'b0010);
        wait_frame("wd_commit_seen");
        repeat (99) @(negedge clk);
        check("wd_not_yet", 32'(blanked), 32'd0);
        @(negedge clk);
        check("wd_blanked", 32'(blanked), 32'd1);
        check("wd_bs_vec", 32'(bs_vec), 32'd0);
        for (int r = 0; r < 4; r++) mdl_row[r] = 32'd0;
        read_chk(7'h00, "wd_rd_00");
        read_chk(7'h7F, "wd_rd_7f");
        rand_reads(4, "wd_rd_rand");
        segA = 16'h5555; segB = 16'hAAAA;
        expect_frame(4'b1111);
        scan(8'hE4, 20, 20, 4'b1111);
        check("wd_recover_blanked", 32'(blanked), 32'd0);
        check("wd_recover_cnt", 32'(frame_cnt), 32'd4);
        check("wd_recover_drain", exp_q.size(), 32'd0);
        read_chk(7'h00, "wd_recover_rd_00");

        // Reset in the middle of common 2
        segA = 16'hFFFF; segB = 16'hFFFF;
        H = 4'b0001; repeat (20) @(negedge clk);
        H = 4'b0010; repeat (20) @(negedge clk);
        H = 4'b0100; repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        check("mid_rst_cnt", 32'(frame_cnt), 32'd0);
        check("mid_rst_bs_vec", 32'(bs_vec), 32'd0);
        check("mid_rst_blanked", 32'(blanked), 32'd1);
        check("mid_rst_frame_done", 32'(frame_done), 32'd0);
        check("mid_rst_rd_data", 32'(rd_data), 32'd0);
        read_chk(7'h00, "mid_rst_rd_00");
        repeat (19) @(negedge clk);
        H = 4'b1000; repeat (20) @(negedge clk);
        check("mid_rst_no_commit", 32'(frame_cnt), 32'd0);
        check("mid_rst_still_blank", 32'(blanked), 32'd1);

        // Commit lands on the watchdog expiry of dut_b
        do_reset();
        segA = 16'hBEEF; segB = 16'hDEAD;
        expect_frame(4'b1001);
        scan(8'hE4, 6, 6, 4'b1001);
        wait_frame_b("coinc_commit_seen");
        check("coinc_blanked", 32'(blanked_b), 32'd0);
        check("coinc_bs_vec", 32'(bs_vec_b), 32'h9);
        check("coinc_frame_cnt", 32'(frame_cnt_b), 32'd1);
        read_chk_b(7'h00, "coinc_rd_00");
        read_chk_b(7'h64, "coinc_rd_64");
        repeat (3) @(negedge clk);
        check("coinc_wd_restart", 32'(blanked_b), 32'd0);
        @(negedge clk);
        check("coinc_wd_expire", 32'(blanked_b), 32'd1);
        check("coinc_drain", exp_q.size(), 32'd0);

        // ---------------- report ----------------
        check("final_drain", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_frame_capture.md
Name: lcd_frame_capture

Overview:
- Receiving end of the SM510 LCD drive interface.
- Watches the time-multiplexed common strobes H, the segment buses segA/segB and the background line Bs.
- Reassembles each complete 4-common scan into a 4x32 segment bitmap plus a 4-bit Bs vector, and commits it atomically to a display buffer.
- The video renderer reads the display buffer through a 1-cycle-latency bit read port; a watchdog blanks the display when scanning stops.

Parameters:
- SETTLE, default 4: clk cycles between an H change and sampling of segA/segB/Bs; range 1..255.
- TIMEOUT, default 1048576: clk cycles without a valid H change before the display buffer is blanked; range 2..2^24-1.

Ports:
- clk  in  1  system clock (same domain as SM510)
- rst  in  1  synchronous, active-high reset
- H  in  4  common strobes, one-hot when valid
- segA  in  16  segments 0-15 for the active common
- segB  in  16  segments 16-31 for the active common
- Bs  in  1  background segment level for the active common
- rd_addr  in  7  [6:5]=common index, [4:0]=segment index
- rd_data  out  1  display buffer bit at rd_addr, registered
- bs_vec  out  4  committed Bs per common
- frame_done  out  1  one-cycle pulse on each commit
- frame_cnt  out  16  number of commits, wraps modulo 2^16
- blanked  out  1  high while the display buffer is forced blank by timeout

Behaviour:
- Reset clears all of the following to 0:
  - display buffer and shadow buffer
  - rd_data, bs_vec, frame_done, frame_cnt
  - settle counter and timeout counter
  - seen mask
- After reset: blanked=1, h_prev=0, FSM=IDLE.
- Edge detect: a change is any cycle with H != h_prev. h_prev is registered every cycle.
- Phase index p = position of the set bit of H. One-hot test: H != 0 and (H & (H-1)) == 0.
- FSM states: IDLE, SETTLE, SAMPLE.
- IDLE:
  - On a change with one-hot H: load settle counter with SETTLE-1 and latch p; go to SETTLE.
  - On a change with non-one-hot H (including H=0): clear the seen mask and stay in IDLE.
- SETTLE:
  - Decrement the counter each cycle; at 0 go to SAMPLE.
  - A new change restarts the sequence: reload the counter, relatch p, or abort to IDLE with the seen mask cleared if H is not one-hot.
- SAMPLE (one cycle):
  - Write shadow[p] = {segB, segA} and shadow_bs[p] = Bs.
  - Ordering rule: seen mask is set to 4'b0001 if p==0; else if seen[p-1]==1 and all bits >= p are 0, set seen[p]; otherwise clear seen. A stray or out-of-order common therefore restarts assembly.
  - Commit when p==3 and seen becomes 4'b1111. The commit happens in the cycle after SAMPLE:
    - display <= shadow, bs_vec <= shadow_bs
    - frame_done=1, frame_cnt+1, blanked<=0
    - seen cleared
  - Return to IDLE.
- Timeout counter:
  - Resets to 0 on every valid one-hot change; otherwise increments, saturating at TIMEOUT.
  - On reaching TIMEOUT: display and bs_vec are cleared in one cycle, blanked=1, seen cleared.
  - The next commit clears blanked.
- Simultaneous commit and timeout in the same cycle: the commit wins and the timeout counter resets.
- Read port: rd_data <= display[rd_addr[6:5]][rd_addr[4:0]], latency 1 cycle. A read in the commit cycle returns the old data; the next cycle returns the new data.
- Reset mid-frame: a partial shadow is discarded and no frame_done is issued.
- All arithmetic is unsigned. Counters are sized to their parameters, and counters never wrap except frame_cnt.

Decomposition:
- Shared package lcd_pkg holds:
  - NUM_COM=4, SEG_PER_COM=32
  - typedef seg_row_t (logic [31:0]), seg_frame_t (seg_row_t [3:0])
  - FSM state enum
- The rd_addr field split is also a package function.
- One sub-module is natural: lcd_phase_detect. It contains h_prev, change detect, the one-hot check, the encoder to p, and the settle counter. It outputs a sample strobe with p and an abort strobe.
- The top level holds the seen mask, shadow and display buffers, watchdog and read port.

Test Plan:
- Basic scan: H=0001,0010,0100,1000 with SETTLE=4, each held 20 cycles; segA=16'hA5A5, segB=16'h0F0F, Bs=1 on common 2 only.
  - Expected: one frame_done, frame_cnt=1, bs_vec=4'b0100, blanked=0.
  - rd_addr=7'h00 -> 1, rd_addr=7'h01 -> 0, rd_addr=7'h30 -> 1.
- Out-of-order commons 0,2,1,3: no commit.
  - A following clean 0,1,2,3 scan commits exactly once, with frame_cnt=1.
- Glitch during settle: H=0001, then 0011 for 2 cycles, then 0010.
  - Expected: the seen mask clears and no row 1 write occurs until a clean scan restarts from common 0.
- Watchdog: TIMEOUT=100; after one valid frame, hold H constant.
  - Expected: at cycle 100, blanked=1, bs_vec=0, and all rd_data reads 0.
  - The next full scan clears blanked and frame_cnt increments.
- Commit versus timeout: arrange for the commit cycle to coincide with the timeout expiry.
  - Expected: frame_done=1, blanked stays 0, and the display holds the new data.
- Reset at common 2 of a scan: rst pulse for 1 cycle.
  - Expected: all outputs return to reset values and blanked=1; the completion of the interrupted scan does not commit.
